jtframe_credits_ctrl: RTL



---
 rtl/jtframe_credits_pkg.sv | 12 +
 rtl/jtframe_frame_debounce.sv | 36 +++
 rtl/jtframe_credits_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/jtframe_credits_pkg.sv
// Shared constants for the credits/pause overlay controller: state encoding and default frame counts.
package jtframe_credits_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARM    = 2'd1;
  localparam logic [1:0] ST_SHOW   = 2'd2;
  localparam logic [1:0] ST_HIDDEN = 2'd3;

  localparam int DEF_HOLD_FRAMES = 30;
  localparam int DEF_HIDE_FRAMES = 1800;

endpackage

// File: rtl/jtframe_frame_debounce.sv
// Per-frame button debouncer: stable flips after 2**DEBW-1 consecutive differing ticks.
// Latency 2**DEBW-1 ticks; no backpressure, samples only on tick.
module jtframe_frame_debounce #(
  parameter int DEBW = 2
)(
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  logic [DEBW-1:0] r_cnt;
  logic [DEBW-1:0] w_inc;
  logic            r_stable;

  assign w_inc  = r_cnt + 1'b1;
  assign stable = r_stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (tick) begin
      if (raw == r_stable) begin
        r_cnt <= '0;
      end else if (&w_inc) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= w_inc;
      end
    end
  end

endmodule

// File: rtl/jtframe_credits_ctrl.sv
// Credits/pause overlay front-end: per-frame FSM driving enable/toggle/fast_scroll/rotate; outputs 1 clk after tick.
// No backpressure. JTFRAME_CREDITS_AUTOHIDE_EN adds an inactivity auto-hide in SHOW.
module jtframe_credits_ctrl
  import jtframe_credits_pkg::*;
#(
  parameter logic BLKPOL      = 1'b1,
  parameter int   DEBW        = 2,
  parameter int   HOLD_FRAMES = DEF_HOLD_FRAMES,
  parameter int   HIDE_FRAMES = DEF_HIDE_FRAMES
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       VB,
  input  logic       pause_req,
  input  logic       btn_toggle,
  input  logic       btn_down,
  input  logic [1:0] rot_cfg,
  output logic       enable,
  output logic       toggle,
  output logic       fast_scroll,
  output logic [1:0] rotate
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  logic          r_last_vb, w_vb, w_tick;
  logic          w_tog_stb, w_dn_stb, r_tog_last, w_press, w_timeout;
  logic [1:0]    r_state, w_nxt;
  logic          w_issue, r_hidden;
  logic          r_enable, r_toggle, r_fast;
  logic [1:0]    r_rotate;
  logic [HW-1:0] r_hold, w_hold_nxt;

  assign w_vb   = (VB == BLKPOL);
  assign w_tick = pxl_cen & w_vb & ~r_last_vb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_last_vb <= 1'b0;
    else if (pxl_cen) r_last_vb <= w_vb;
  end

  jtframe_frame_debounce #(.DEBW(DEBW)) u_deb_toggle (
    .clk(clk), .rst_n(rst_n), .tick(w_tick), .raw(btn_toggle), .stable(w_tog_stb)
  );

  jtframe_frame_debounce #(.DEBW(DEBW)) u_deb_down (
    .clk(clk), .rst_n(rst_n), .tick(w_tick), .raw(btn_down), .stable(w_dn_stb)
  );

  // r_tog_last advances every tick, so an edge arriving during ARM is consumed there.
  assign w_press = w_tog_stb & ~r_tog_last;

`ifdef JTFRAME_CREDITS_AUTOHIDE_EN
  localparam int IW = $clog2(HIDE_FRAMES + 1);
  logic [IW-1:0] r_idle;
  logic          r_dn_last, w_btn_chg;

  assign w_btn_chg = (w_tog_stb != r_tog_last) | (w_dn_stb != r_dn_last);
  assign w_timeout = (r_state == ST_SHOW) & ~w_btn_chg & (r_idle == IW'(HIDE_FRAMES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle    <= '0;
      r_dn_last <= 1'b0;
    end else if (w_tick) begin
      r_dn_last <= w_dn_stb;
      if (r_state == ST_SHOW && pause_req && !w_btn_chg && !w_timeout) r_idle <= r_idle + 1'b1;
      else                                                             r_idle <= '0;
    end
  end
`else
  logic w_unused_hide;
  assign w_unused_hide = ^HIDE_FRAMES;
  assign w_timeout     = 1'b0;
`endif

  always_comb begin
    w_nxt   = r_state;
    w_issue = 1'b0;
    if (!pause_req) begin
      w_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_nxt = ST_ARM;
        ST_ARM: begin
          w_issue = r_hidden;
          w_nxt   = ST_SHOW;
        end
        ST_SHOW: if (w_press | w_timeout) begin
          w_issue = 1'b1;
          w_nxt   = ST_HIDDEN;
        end
        default: if (w_press) begin
          w_issue = 1'b1;
          w_nxt   = ST_SHOW;
        end
      endcase
    end
  end

  always_comb begin
    w_hold_nxt = '0;
    if (w_dn_stb && r_state == ST_SHOW)
      w_hold_nxt = (r_hold == HW'(HOLD_FRAMES)) ? r_hold : r_hold + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_hidden   <= 1'b0;
      r_tog_last <= 1'b0;
      r_enable   <= 1'b0;
      r_toggle   <= 1'b0;
      r_fast     <= 1'b0;
      r_hold     <= '0;
      r_rotate   <= 2'b00;
    end else if (w_tick) begin
      r_state    <= w_nxt;
      r_enable   <= (w_nxt != ST_IDLE);
      r_toggle   <= w_issue;
      r_hidden   <= r_hidden ^ w_issue;
      r_tog_last <= w_tog_stb;
      r_hold     <= w_hold_nxt;
      r_fast     <= (w_hold_nxt == HW'(HOLD_FRAMES));
      if (r_state == ST_IDLE && !pause_req) r_rotate <= rot_cfg;
    end else if (!pause_req) begin
      // Leaving pause truncates a pulse in flight rather than waiting for the next frame.
      r_toggle <= 1'b0;
    end
  end

  assign enable      = r_enable;
  assign toggle      = r_toggle;
  assign fast_scroll = r_fast;
  assign rotate      = r_rotate;

endmodule
